// File: rtl/locker_pkg.sv
// Shared definitions for the 2-digit locker: FSM state encodings, BCD limit and
// the 7-segment pattern table used by the display decoders.
package locker_pkg;

  localparam logic [2:0] ST_LOCKED   = 3'd0;
  localparam logic [2:0] ST_UNLOCKED = 3'd1;
  localparam logic [2:0] ST_CHANGE   = 3'd2;
  localparam logic [2:0] ST_ALARM    = 3'd3;

  localparam logic [3:0] BCD_MAX = 4'd9;

  // Segment order {g,f,e,d,c,b,a}, active high; non-BCD values show a dash.
  localparam logic [6:0] SEG7_TABLE [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40
  };

  function automatic logic [6:0] seg7_decode(input logic [3:0] digit);
    return SEG7_TABLE[digit];
  endfunction

  function automatic logic is_bcd(input logic [3:0] digit);
    return (digit <= BCD_MAX);
  endfunction

endpackage

// File: rtl/locker_down_timer.sv
// Loadable down-counter that stops at zero; zero_o flags an expired count.
module locker_down_timer #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic [WIDTH-1:0] value_i,
  input  logic             en_i,
  output logic             zero_o
);

  logic [WIDTH-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = value_i;
    end else if (en_i && (count_q != '0)) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign zero_o = (count_q == '0);

endmodule

// File: rtl/locker_seq_ctrl.sv
// Locker sequencing FSM: entry buffer, stored password, error count, lockout.
// Optional auto-relock from UNLOCKED is enabled by defining LOCKER_AUTO_RELOCK_EN.
module locker_seq_ctrl
  import locker_pkg::*;
#(
  parameter logic [7:0]  DEFAULT_PWD   = 8'h11,
  parameter int unsigned MAX_ERR       = 3,
  parameter int unsigned LOCK_CYCLES   = 50_000_000,
  parameter int unsigned UNLOCK_CYCLES = 250_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] switch,
  input  logic       dig0_p,
  input  logic       dig1_p,
  input  logic       confirm_p,
  input  logic       chg_p,
  output logic [3:0] code0,
  output logic [3:0] code1,
  output logic       unlocked,
  output logic       alarm,
  output logic [1:0] err_cnt,
  output logic [2:0] state
);

  localparam int unsigned   LOCK_W    = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;
  localparam logic [LOCK_W-1:0] LOCK_LOAD = LOCK_W'(LOCK_CYCLES - 1);
  localparam logic [1:0]    MAX_ERR_L = 2'(MAX_ERR);
  localparam logic [2:0]    MAX_ERR_W = 3'(MAX_ERR);

  // Out-of-range configurations leave this marker block in the elaborated tree.
  if (MAX_ERR == 0 || MAX_ERR > 3 || LOCK_CYCLES == 0 || UNLOCK_CYCLES == 0) begin : g_cfg_invalid
  end

  logic [2:0] state_q, state_d;
  logic [3:0] code0_q, code0_d, code1_q, code1_d;
  logic [1:0] err_q, err_d;
  logic [7:0] pwd_q, pwd_d;
  logic       unlocked_q, alarm_q;

  logic take_dig0, take_dig1, take_conf, take_chg;
  logic code_ok, code_match;
  logic [2:0] err_next;
  logic lock_load, lock_zero;

  // Only the highest-priority pulse in a cycle is acted upon.
  always_comb begin
    take_dig0 = dig0_p;
    take_dig1 = dig1_p & ~dig0_p;
    take_conf = confirm_p & ~dig0_p & ~dig1_p;
    take_chg  = chg_p & ~dig0_p & ~dig1_p & ~confirm_p;
  end

  assign code_ok    = is_bcd(code1_q) && is_bcd(code0_q);
  assign code_match = code_ok && ({code1_q, code0_q} == pwd_q);
  assign err_next   = {1'b0, err_q} + 3'd1;

  locker_down_timer #(
    .WIDTH (LOCK_W)
  ) u_lock_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .load_i  (lock_load),
    .value_i (LOCK_LOAD),
    .en_i    (state_q == ST_ALARM),
    .zero_o  (lock_zero)
  );

`ifdef LOCKER_AUTO_RELOCK_EN
  localparam int unsigned RELOCK_W = (UNLOCK_CYCLES > 1) ? $clog2(UNLOCK_CYCLES) : 1;
  localparam logic [RELOCK_W-1:0] RELOCK_LOAD = RELOCK_W'(UNLOCK_CYCLES - 1);

  logic relock_load, relock_zero;

  // Reload on every entry to UNLOCKED; CHANGE leaves the count untouched.
  assign relock_load = ((state_d == ST_UNLOCKED) && (state_q != ST_UNLOCKED)) ||
                       ((state_q == ST_UNLOCKED) && (take_conf || take_chg));

  locker_down_timer #(
    .WIDTH (RELOCK_W)
  ) u_relock_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .load_i  (relock_load),
    .value_i (RELOCK_LOAD),
    .en_i    (state_q == ST_UNLOCKED),
    .zero_o  (relock_zero)
  );
`endif

  always_comb begin
    state_d   = state_q;
    code0_d   = code0_q;
    code1_d   = code1_q;
    err_d     = err_q;
    pwd_d     = pwd_q;
    lock_load = 1'b0;
    case (state_q)
      ST_LOCKED: begin
        if (take_dig0) begin
          code0_d = switch;
        end else if (take_dig1) begin
          code1_d = switch;
        end else if (take_conf) begin
          if (code_match) begin
            state_d = ST_UNLOCKED;
            err_d   = '0;
          end else if (err_next >= MAX_ERR_W) begin
            state_d   = ST_ALARM;
            err_d     = MAX_ERR_L;
            lock_load = 1'b1;
          end else begin
            err_d = err_next[1:0];
          end
        end
      end
      ST_UNLOCKED: begin
        if (take_conf) begin
          state_d = ST_LOCKED;
          code0_d = '0;
          code1_d = '0;
        end else if (take_chg) begin
          state_d = ST_CHANGE;
          code0_d = '0;
          code1_d = '0;
        end
`ifdef LOCKER_AUTO_RELOCK_EN
        else if (relock_zero) begin
          state_d = ST_LOCKED;
          code0_d = '0;
          code1_d = '0;
        end
`endif
      end
      ST_CHANGE: begin
        if (take_dig0) begin
          code0_d = switch;
        end else if (take_dig1) begin
          code1_d = switch;
        end else if (take_conf) begin
          if (code_ok) begin
            pwd_d   = {code1_q, code0_q};
            state_d = ST_UNLOCKED;
          end
        end else if (take_chg) begin
          state_d = ST_UNLOCKED;
        end
      end
      ST_ALARM: begin
        if (lock_zero) begin
          state_d = ST_LOCKED;
          err_d   = '0;
          code0_d = '0;
          code1_d = '0;
        end
      end
      default: begin
        state_d = ST_LOCKED;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_LOCKED;
      code0_q    <= '0;
      code1_q    <= '0;
      err_q      <= '0;
      pwd_q      <= DEFAULT_PWD;
      unlocked_q <= 1'b0;
      alarm_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      code0_q    <= code0_d;
      code1_q    <= code1_d;
      err_q      <= err_d;
      pwd_q      <= pwd_d;
      unlocked_q <= (state_d == ST_UNLOCKED) || (state_d == ST_CHANGE);
      alarm_q    <= (state_d == ST_ALARM);
    end
  end

  assign code0    = code0_q;
  assign code1    = code1_q;
  assign err_cnt  = err_q;
  assign state    = state_q;
  assign unlocked = unlocked_q;
  assign alarm    = alarm_q;

endmodule

// File: tb/tb_locker_seq_ctrl.sv
// Scoreboard bench for locker_seq_ctrl with a short lockout (LOCK_CYCLES=8).
module tb_locker_seq_ctrl;

  localparam logic [2:0] S_LCK = 3'd0;
  localparam logic [2:0] S_UNL = 3'd1;
  localparam logic [2:0] S_CHG = 3'd2;
  localparam logic [2:0] S_ALM = 3'd3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] switch = '0;
  logic       dig0_p = 1'b0, dig1_p = 1'b0, confirm_p = 1'b0, chg_p = 1'b0;
  logic [3:0] code0, code1;
  logic       unlocked, alarm;
  logic [1:0] err_cnt;
  logic [2:0] state;

  int checks = 0;
  int failures = 0;

  typedef struct {
    string      tag;
    logic       d0, d1, cf, cg;
    logic [3:0] sw;
    logic [14:0] exp;
  } step_t;

  typedef struct {
    string       tag;
    logic [14:0] v;
  } exp_t;

  exp_t sbq[$];

  locker_seq_ctrl #(
    .DEFAULT_PWD   (8'h11),
    .MAX_ERR       (3),
    .LOCK_CYCLES   (8),
    .UNLOCK_CYCLES (10)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .switch    (switch),
    .dig0_p    (dig0_p),
    .dig1_p    (dig1_p),
    .confirm_p (confirm_p),
    .chg_p     (chg_p),
    .code0     (code0),
    .code1     (code1),
    .unlocked  (unlocked),
    .alarm     (alarm),
    .err_cnt   (err_cnt),
    .state     (state)
  );

  always #5 clk = ~clk;

  function automatic logic [14:0] pk(input logic [2:0] s, input logic [1:0] e,
                                     input logic u, input logic a,
                                     input logic [3:0] c1, input logic [3:0] c0);
    return {s, e, u, a, c1, c0};
  endfunction

  function automatic logic [14:0] obs();
    return {state, err_cnt, unlocked, alarm, code1, code0};
  endfunction

  function automatic step_t mk(input string tag, input logic d0, input logic d1,
                               input logic cf, input logic cg, input logic [3:0] sw,
                               input logic [14:0] exp);
    step_t s;
    s.tag = tag; s.d0 = d0; s.d1 = d1; s.cf = cf; s.cg = cg; s.sw = sw; s.exp = exp;
    return s;
  endfunction

  // Called at a negedge: drive for one posedge, return at the following negedge.
  task automatic pulse(input logic d0, input logic d1, input logic cf,
                       input logic cg, input logic [3:0] sw);
    switch = sw; dig0_p = d0; dig1_p = d1; confirm_p = cf; chg_p = cg;
    @(negedge clk);
    dig0_p = 1'b0; dig1_p = 1'b0; confirm_p = 1'b0; chg_p = 1'b0;
  endtask

  task automatic run_steps(input step_t st[$]);
    exp_t e;
    foreach (st[i]) begin
      sbq.push_back('{st[i].tag, st[i].exp});
      pulse(st[i].d0, st[i].d1, st[i].cf, st[i].cg, st[i].sw);
      e = sbq.pop_front();
      checks++;
      if (obs() !== e.v) begin
        failures++;
        $display("FAIL %s got=%h exp=%h", e.tag, obs(), e.v);
      end
    end
  endtask

  task automatic test_reset();
    exp_t e;
    rst_n = 1'b0;
    sbq.push_back('{"reset_values", pk(S_LCK, 2'd0, 1'b0, 1'b0, 4'h0, 4'h0)});
    repeat (2) @(negedge clk);
    e = sbq.pop_front();
    checks++;
    if (obs() !== e.v) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", e.tag, obs(), e.v);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_unlock();
    step_t st[$];
    st.push_back(mk("unl_dig0",  1, 0, 0, 0, 4'd1, pk(S_LCK, 2'd0, 0, 0, 4'h0, 4'h1)));
    st.push_back(mk("unl_dig1",  0, 1, 0, 0, 4'd1, pk(S_LCK, 2'd0, 0, 0, 4'h1, 4'h1)));
    st.push_back(mk("unl_conf",  0, 0, 1, 0, 4'd0, pk(S_UNL, 2'd0, 1, 0, 4'h1, 4'h1)));
    st.push_back(mk("unl_relock",0, 0, 1, 0, 4'd0, pk(S_LCK, 2'd0, 0, 0, 4'h0, 4'h0)));
    run_steps(st);
  endtask

  task automatic test_alarm();
    step_t st[$];
    exp_t  e;
    int    n;
    st.push_back(mk("alm_dig0", 1, 0, 0, 0, 4'd2, pk(S_LCK, 2'd0, 0, 0, 4'h0, 4'h2)));
    st.push_back(mk("alm_dig1", 0, 1, 0, 0, 4'd2, pk(S_LCK, 2'd0, 0, 0, 4'h2, 4'h2)));
    st.push_back(mk("alm_err1", 0, 0, 1, 0, 4'd0, pk(S_LCK, 2'd1, 0, 0, 4'h2, 4'h2)));
    st.push_back(mk("alm_err2", 0, 0, 1, 0, 4'd0, pk(S_LCK, 2'd2, 0, 0, 4'h2, 4'h2)));
    st.push_back(mk("alm_enter",0, 0, 1, 0, 4'd0, pk(S_ALM, 2'd3, 0, 1, 4'h2, 4'h2)));
    st.push_back(mk("alm_ign_dig0", 1, 0, 0, 0, 4'd5, pk(S_ALM, 2'd3, 0, 1, 4'h2, 4'h2)));
    run_steps(st);
    n = 2;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (alarm) n++;
      else break;
    end
    sbq.push_back('{"alm_duration", 15'(8)});
    e = sbq.pop_front();
    checks++;
    if (15'(n) !== e.v) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", e.tag, n, e.v);
    end
    sbq.push_back('{"alm_exit", pk(S_LCK, 2'd0, 0, 0, 4'h0, 4'h0)});
    e = sbq.pop_front();
    checks++;
    if (obs() !== e.v) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", e.tag, obs(), e.v);
    end
  endtask

  task automatic test_change();
    step_t st[$];
    st.push_back(mk("chg_d0",    1, 0, 0, 0, 4'd1, pk(S_LCK, 2'd0, 0, 0, 4'h0, 4'h1)));
    st.push_back(mk("chg_d1",    0, 1, 0, 0, 4'd1, pk(S_LCK, 2'd0, 0, 0, 4'h1, 4'h1)));
    st.push_back(mk("chg_unl",   0, 0, 1, 0, 4'd0, pk(S_UNL, 2'd0, 1, 0, 4'h1, 4'h1)));
    st.push_back(mk("chg_enter", 0, 0, 0, 1, 4'd0, pk(S_CHG, 2'd0, 1, 0, 4'h0, 4'h0)));
    st.push_back(mk("chg_new0",  1, 0, 0, 0, 4'd7, pk(S_CHG, 2'd0, 1, 0, 4'h0, 4'h7)));
    st.push_back(mk("chg_new1",  0, 1, 0, 0, 4'd4, pk(S_CHG, 2'd0, 1, 0, 4'h4, 4'h7)));
    st.push_back(mk("chg_commit",0, 0, 1, 0, 4'd0, pk(S_UNL, 2'd0, 1, 0, 4'h4, 4'h7)));
    st.push_back(mk("chg_lock",  0, 0, 1, 0, 4'd0, pk(S_LCK, 2'd0, 0, 0, 4'h0, 4'h0)));
    st.push_back(mk("old_d0",    1, 0, 0, 0, 4'd1, pk(S_LCK, 2'd0, 0, 0, 4'h0, 4'h1)));
    st.push_back(mk("old_d1",    0, 1, 0, 0, 4'd1, pk(S_LCK, 2'd0, 0, 0, 4'h1, 4'h1)));
    st.push_back(mk("old_pwd_fails", 0, 0, 1, 0, 4'd0, pk(S_LCK, 2'd1, 0, 0, 4'h1, 4'h1)));
    st.push_back(mk("new_d0",    1, 0, 0, 0, 4'd7, pk(S_LCK, 2'd1, 0, 0, 4'h1, 4'h7)));
    st.push_back(mk("new_d1",    0, 1, 0, 0, 4'd4, pk(S_LCK, 2'd1, 0, 0, 4'h4, 4'h7)));
    st.push_back(mk("new_pwd_unl", 0, 0, 1, 0, 4'd0, pk(S_UNL, 2'd0, 1, 0, 4'h4, 4'h7)));
    run_steps(st);
  endtask

  task automatic test_bad_digit();
    step_t st[$];
    st.push_back(mk("bad_enter", 0, 0, 0, 1, 4'd0,  pk(S_CHG, 2'd0, 1, 0, 4'h0, 4'h0)));
    st.push_back(mk("bad_d0",    1, 0, 0, 0, 4'd12, pk(S_CHG, 2'd0, 1, 0, 4'h0, 4'hC)));
    st.push_back(mk("bad_d1",    0, 1, 0, 0, 4'd3,  pk(S_CHG, 2'd0, 1, 0, 4'h3, 4'hC)));
    st.push_back(mk("bad_commit_stay", 0, 0, 1, 0, 4'd0, pk(S_CHG, 2'd0, 1, 0, 4'h3, 4'hC)));
    st.push_back(mk("bad_abort", 0, 0, 0, 1, 4'd0,  pk(S_UNL, 2'd0, 1, 0, 4'h3, 4'hC)));
    st.push_back(mk("bad_lock",  0, 0, 1, 0, 4'd0,  pk(S_LCK, 2'd0, 0, 0, 4'h0, 4'h0)));
    st.push_back(mk("keep_d0",   1, 0, 0, 0, 4'd7,  pk(S_LCK, 2'd0, 0, 0, 4'h0, 4'h7)));
    st.push_back(mk("keep_d1",   0, 1, 0, 0, 4'd4,  pk(S_LCK, 2'd0, 0, 0, 4'h4, 4'h7)));
    st.push_back(mk("pwd_unchanged", 0, 0, 1, 0, 4'd0, pk(S_UNL, 2'd0, 1, 0, 4'h4, 4'h7)));
    st.push_back(mk("keep_lock", 0, 0, 1, 0, 4'd0,  pk(S_LCK, 2'd0, 0, 0, 4'h0, 4'h0)));
    run_steps(st);
  endtask

  task automatic test_priority();
    step_t st[$];
    st.push_back(mk("pri_d1",       0, 1, 0, 0, 4'd4, pk(S_LCK, 2'd0, 0, 0, 4'h4, 4'h0)));
    st.push_back(mk("pri_d0_over_cf", 1, 0, 1, 0, 4'd7, pk(S_LCK, 2'd0, 0, 0, 4'h4, 4'h7)));
    st.push_back(mk("pri_unl",      0, 0, 1, 0, 4'd0, pk(S_UNL, 2'd0, 1, 0, 4'h4, 4'h7)));
    st.push_back(mk("unl_ign_dig0", 1, 0, 0, 0, 4'd9, pk(S_UNL, 2'd0, 1, 0, 4'h4, 4'h7)));
    st.push_back(mk("pri_cf_over_chg", 0, 0, 1, 1, 4'd0, pk(S_LCK, 2'd0, 0, 0, 4'h0, 4'h0)));
    run_steps(st);
  endtask

  task automatic test_reset_mid_alarm();
    step_t st[$];
    exp_t  e;
    st.push_back(mk("rma_err1",  0, 0, 1, 0, 4'd0, pk(S_LCK, 2'd1, 0, 0, 4'h0, 4'h0)));
    st.push_back(mk("rma_err2",  0, 0, 1, 0, 4'd0, pk(S_LCK, 2'd2, 0, 0, 4'h0, 4'h0)));
    st.push_back(mk("rma_alarm", 0, 0, 1, 0, 4'd0, pk(S_ALM, 2'd3, 0, 1, 4'h0, 4'h0)));
    run_steps(st);
    #2 rst_n = 1'b0;
    sbq.push_back('{"rma_async", pk(S_LCK, 2'd0, 0, 0, 4'h0, 4'h0)});
    #1;
    e = sbq.pop_front();
    checks++;
    if (obs() !== e.v) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", e.tag, obs(), e.v);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    st.delete();
    st.push_back(mk("rma_d0",  1, 0, 0, 0, 4'd1, pk(S_LCK, 2'd0, 0, 0, 4'h0, 4'h1)));
    st.push_back(mk("rma_d1",  0, 1, 0, 0, 4'd1, pk(S_LCK, 2'd0, 0, 0, 4'h1, 4'h1)));
    st.push_back(mk("rma_default_pwd", 0, 0, 1, 0, 4'd0, pk(S_UNL, 2'd0, 1, 0, 4'h1, 4'h1)));
    run_steps(st);
  endtask

`ifdef LOCKER_AUTO_RELOCK_EN
  task automatic test_auto_relock();
    exp_t e;
    int   n;
    n = 1;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (state == S_UNL) n++;
      else break;
    end
    sbq.push_back('{"relock_cycles", 15'(10)});
    e = sbq.pop_front();
    checks++;
    if (15'(n) !== e.v) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", e.tag, n, e.v);
    end
  endtask
`endif

  initial begin
    @(negedge clk);
    test_reset();
    test_unlock();
    test_alarm();
    test_change();
    test_bad_digit();
    test_priority();
    test_reset_mid_alarm();
`ifdef LOCKER_AUTO_RELOCK_EN
    test_auto_relock();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/locker_seq_ctrl.md
Name: locker_seq_ctrl

Overview:
- Sequencing controller for the 2-digit locker datapath: owns the entry buffer, stored password, error counter, lockout timer and unlock/change-password modes.
- Consumes one-cycle pulses from the existing debounce block.
- Drives the digit values to the 7-segment decoders, plus status LEDs.
- Replaces ad-hoc flag logic with one explicit FSM so password change is only possible while unlocked.

Parameters:
- DEFAULT_PWD, 8'h11, reset password: [7:4] = digit1, [3:0] = digit0, BCD.
- MAX_ERR, 3, consecutive wrong confirms that trigger ALARM (1..3).
- LOCK_CYCLES, 50_000_000, ALARM duration in clk cycles (>= 1).
- UNLOCK_CYCLES, 250_000_000, auto-relock timeout; used only with the optional feature.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- switch  in  4  digit value from DIP switches
- dig0_p  in  1  debounced pulse: load switch into entry digit 0
- dig1_p  in  1  debounced pulse: load switch into entry digit 1
- confirm_p  in  1  debounced pulse: check code / commit new password / relock
- chg_p  in  1  debounced pulse: request password change (honoured only in UNLOCKED)
- code0  out  4  entry digit 0, to segment decoder
- code1  out  4  entry digit 1, to segment decoder
- unlocked  out  1  high in UNLOCKED and CHANGE
- alarm  out  1  high in ALARM
- err_cnt  out  2  consecutive wrong attempts
- state  out  3  FSM state encoding, for debug and LEDs

Behaviour:
- Reset (async):
  - state=LOCKED; code0=code1=0; err_cnt=0; unlocked=0; alarm=0.
  - Password register = DEFAULT_PWD; timers = 0.
- All outputs are registered. Pulse priority in one cycle: dig0_p > dig1_p > confirm_p > chg_p; lower-priority pulses in that cycle are dropped.
- Digit loads: dig0_p/dig1_p load switch into code0/code1 in LOCKED and CHANGE only; ignored in UNLOCKED and ALARM.
- Digit range: switch values 10..15 are stored as-is. A comparison involving such a value always fails. The display shows them per the decoder default.

LOCKED:
- On confirm_p, compare {code1,code0} with the password register. The result is visible on the next clock edge (1-cycle latency).
- Match: go to UNLOCKED, err_cnt=0.
- Mismatch, err_cnt+1 < MAX_ERR: err_cnt increments, stay LOCKED.
- Mismatch, err_cnt+1 == MAX_ERR: err_cnt=MAX_ERR, go to ALARM, load lockout timer with LOCK_CYCLES-1.

ALARM:
- All pulses ignored. Timer decrements once per cycle.
- When the timer is 0: go to LOCKED, err_cnt=0, code0=code1=0. alarm is high for exactly LOCK_CYCLES cycles.

UNLOCKED:
- chg_p goes to CHANGE and clears code0/code1.
- confirm_p goes to LOCKED and clears code0/code1.

CHANGE:
- Digits are entered as above.
- confirm_p writes {code1,code0} to the password register only if both digits are <= 9, then goes to UNLOCKED.
- If either digit is > 9: no write, stay in CHANGE.
- chg_p in CHANGE aborts to UNLOCKED with no write.

Other rules:
- The old password is invalid immediately after commit; there is no dual-password acceptance.
- err_cnt saturates and never wraps.
- Reset asserted mid-ALARM or mid-CHANGE returns everything to reset values, including the password register (restored to DEFAULT_PWD).

Optional Feature:
- Macro: LOCKER_AUTO_RELOCK_EN.
- Defined:
  - On entry to UNLOCKED, a relock timer loads UNLOCK_CYCLES-1.
  - It decrements each cycle in UNLOCKED and reloads on any accepted pulse.
  - At 0 it goes to LOCKED and clears code0/code1.
  - CHANGE freezes the timer; returning to UNLOCKED reloads it.
- Undefined: no relock timer or logic is generated. UNLOCKED persists until confirm_p or reset.

Decomposition:
- Package locker_pkg holds:
  - state encodings: LOCKED=0, UNLOCKED=1, CHANGE=2, ALARM=3;
  - BCD_MAX=9;
  - the shared 7-segment constant table used by the display decoder.
- One sub-module, locker_down_timer (parameter WIDTH; load, value, enable, zero flag). It is instantiated for lockout and, when the macro is defined, for relock.

Test Plan:
- Reset, then switch=1, dig0_p, dig1_p, confirm_p -> next cycle state=UNLOCKED, unlocked=1, err_cnt=0.
- Wrong code 2/2 confirmed 3 times -> err_cnt 1, 2, then alarm=1, state=ALARM. With LOCK_CYCLES=8, alarm is high exactly 8 cycles, then LOCKED with err_cnt=0; dig0_p during ALARM leaves code0 unchanged.
- Unlock, chg_p, enter 4/7, confirm_p -> UNLOCKED. Then confirm_p -> LOCKED. Code 1/1 now fails (err_cnt=1); code 7/4 (digit1=4, digit0=7) unlocks.
- In CHANGE, enter digit 12 and confirm_p -> stays CHANGE, password unchanged. Then chg_p -> UNLOCKED.
- dig0_p and confirm_p in the same cycle -> only code0 is loaded, no compare. Async rst_n low mid-ALARM -> immediate LOCKED, alarm=0, password=8'h11.
- With LOCKER_AUTO_RELOCK_EN and UNLOCK_CYCLES=10: unlock, then idle 10 cycles -> LOCKED. A chg_p at cycle 5 holds CHANGE indefinitely.
